fetch_stage: RTL and testbench
==============================

# fetch_stage

- Instruction fetch stage that sits directly upstream of the decode/controller logic.
- Owns the program counter and issues word fetches to an instruction memory over a request/response handshake.
- Buffers returned instructions in a small fetch queue and presents them in order, each with its PC and PC+4, to the decode stage.
- Handles branch/jump redirects by flushing the queue and discarding any stale in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- DEPTH, 2, fetch queue entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IMemReq  out  1  fetch request valid.
- IMemAddr  out  32  fetch word address (byte address, [1:0]=0).
- IMemReady  in  1  memory accepts request this cycle.
- IMemRValid  in  1  read data valid; at most one response per accepted request, in order.
- IMemRData  in  32  instruction word.
- RedirectValid  in  1  taken branch/jump from execute.
- RedirectPC  in  32  redirect target; bits [1:0] ignored (forced 0).
- InstrReady  in  1  decode accepts head instruction.
- InstrValid  out  1  queue head valid.
- Instr  out  32  head instruction.
- InstrPC  out  32  PC of head.
- InstrPCPlus4  out  32  InstrPC + 4 (modulo 2^32).

## Operation
- State: PC, Outstanding (0/1, at most one request in flight), Discard flag, queue of DEPTH {pc, instr} entries, Count.
- Reset values:
  - PC=RESET_PC, Outstanding=0, Discard=0, Count=0.
  - Outputs: InstrValid=0, Instr/InstrPC=0, InstrPCPlus4=4, IMemReq=0 while RST_N low.
- Pop = InstrValid & InstrReady. Free = DEPTH − Count − Outstanding + Pop.
- Issue rule: IMemReq = (Outstanding==0 | IMemRValid) & Free≥1; IMemAddr=PC. IMemReq depends combinationally on InstrReady and IMemRValid but never on RedirectValid.
- Accept (IMemReq & IMemReady): PC←PC+4 (wraps at 2^32), Outstanding←1, and the entry's pc is latched as FetchPC.
- Response (IMemRValid with Outstanding=1):
  - Discard=0: push {FetchPC, IMemRData}.
  - Discard=1: drop the data and clear Discard.
  - Outstanding←0 unless a new request is accepted the same cycle.
  - IMemRValid with Outstanding=0 is ignored.
- Redirect (RedirectValid=1):
  - Queue cleared (Count←0); any pop that cycle still completes (decode consumed the old head).
  - PC←{RedirectPC[31:2],2'b00}.
  - If a request is in flight after this edge (old outstanding with no response this cycle, or a request accepted this cycle), Discard←1.
  - Redirect has priority over push: a response arriving in the redirect cycle is dropped.
- Simultaneous push and pop: Count unchanged, queue order preserved.
- Full: Free=0 holds IMemReq low; the queue never overflows. Empty: InstrValid=0.
- Output fields come from queue registers only (no bypass of IMemRData).

## Timing
- Memory with zero-wait accept and response one cycle after accept: first InstrValid appears 2 cycles after the first accepted request.
- Sustained throughput with DEPTH≥2 and decode always ready: 1 instruction/cycle.
- Redirect at edge N: fetch from the target is requested in cycle N+1, or after the discarded response if one is in flight. The first target instruction is valid no earlier than N+3.
- Reset asserted mid-operation: all state cleared immediately; any in-flight response after release is ignored because Outstanding=0.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output ports PerfFetchCnt[31:0] and PerfStarveCnt[31:0].
  - PerfFetchCnt counts pops. PerfStarveCnt counts cycles with InstrReady=1 and InstrValid=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013 at every address, InstrReady=1 -> IMemAddr 0,4,8,… on consecutive cycles; InstrPC 0,4,8,… one per cycle from the 3rd cycle; InstrPCPlus4=InstrPC+4.
- InstrReady=0 for 10 cycles -> Count saturates at DEPTH, IMemReq low, no responses lost; on release, PCs continue in order without gaps.
- Redirect to 32'h0000_0103 while a response is in flight -> the stale response is dropped, the next IMemAddr is 32'h0000_0100, and the first InstrPC after the redirect is 32'h0000_0100.
- Memory with IMemReady low for 3 cycles, then response latency 4 -> IMemAddr held stable, exactly one outstanding request, in-order delivery.
- PC at 32'hFFFF_FFFC -> next IMemAddr is 0; InstrPCPlus4 is 0 for the head at 32'hFFFF_FFFC.
- RST_N pulsed low mid-stream with Count=2 -> InstrValid drops asynchronously; after release, fetch restarts at RESET_PC; with FETCH_PERF_CNT_EN both counters read 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one fetch in flight and buffers
// returned words in a DEPTH-entry queue. FETCH_PERF_CNT_EN adds pop/starve counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic        IMemRValid,
  input  logic [31:0] IMemRData,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectPC,
  input  logic        InstrReady,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] InstrPCPlus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] PerfFetchCnt,
  output logic [31:0] PerfStarveCnt
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int FW   = AW + 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  logic [31:0]                 pc_q, pc_d;
  logic [31:0]                 fpc_q, fpc_d;
  logic                        out_q, out_d;
  logic                        disc_q, disc_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic [AW-1:0]               hd_q, hd_d, tl_q, tl_d;
  fq_entry_t [DEPTH-1:0]       fq_q, fq_d;

  logic          pop, accept, resp, push;
  logic [FW-1:0] free_w;
  logic [1:0]    unused_redir_lsb;

  assign unused_redir_lsb = RedirectPC[1:0];

  assign InstrValid   = (cnt_q != '0);
  assign Instr        = fq_q[hd_q].instr;
  assign InstrPC      = fq_q[hd_q].pc;
  assign InstrPCPlus4 = fq_q[hd_q].pc + 32'd4;

  assign pop    = InstrValid & InstrReady;
  // Free slots, counting the in-flight request as already occupying one.
  assign free_w = FW'(DEPTH) - FW'(cnt_q) - FW'(out_q) + FW'(pop);

  // Gated by RST_N so the request is quiet while reset is held.
  assign IMemReq  = RST_N & (~out_q | IMemRValid) & (free_w != '0);
  assign IMemAddr = pc_q;
  assign accept   = IMemReq & IMemReady;
  assign resp     = IMemRValid & out_q;
  assign push     = resp & ~disc_q & ~RedirectValid;

  always_comb begin
    pc_d   = pc_q;
    fpc_d  = fpc_q;
    out_d  = out_q;
    disc_d = disc_q;
    hd_d   = hd_q;
    tl_d   = tl_q;
    fq_d   = fq_q;
    cnt_d  = cnt_q + CNTW'(push) - CNTW'(pop);

    if (accept) begin
      pc_d  = pc_q + 32'd4;
      fpc_d = pc_q;
      out_d = 1'b1;
    end else if (resp) begin
      out_d = 1'b0;
    end

    if (resp) disc_d = 1'b0;

    if (push) begin
      fq_d[tl_q] = '{pc: fpc_q, instr: IMemRData};
      tl_d       = tl_q + AW'(1);
    end
    if (pop) hd_d = hd_q + AW'(1);

    // Redirect wins over push; anything still in flight after this edge is stale.
    if (RedirectValid) begin
      pc_d   = {RedirectPC[31:2], 2'b00};
      disc_d = (out_q & ~IMemRValid) | accept;
      cnt_d  = '0;
      hd_d   = '0;
      tl_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q   <= RESET_PC;
      fpc_q  <= '0;
      out_q  <= 1'b0;
      disc_q <= 1'b0;
      cnt_q  <= '0;
      hd_q   <= '0;
      tl_q   <= '0;
      fq_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      fpc_q  <= fpc_d;
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      hd_q   <= hd_d;
      tl_q   <= tl_d;
      fq_q   <= fq_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_starve_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_fetch_q  <= '0;
      perf_starve_q <= '0;
    end else begin
      if (pop)                      perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (InstrReady & ~InstrValid) perf_starve_q <= perf_starve_q + 32'd1;
    end
  end

  assign PerfFetchCnt  = perf_fetch_q;
  assign PerfStarveCnt = perf_starve_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a memory model feeds responses, expected
// {pc, instr} pairs are queued on accepted fetches and checked on each pop.
module tb_fetch_stage;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic        IMemRValid = 1'b0;
  logic [31:0] IMemRData = '0;
  logic        RedirectValid = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        InstrReady = 1'b0;
  logic        InstrValid;
  logic [31:0] Instr, InstrPC, InstrPCPlus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] PerfFetchCnt, PerfStarveCnt;
`endif

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemRValid(IMemRValid), .IMemRData(IMemRData),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
    .InstrReady(InstrReady), .InstrValid(InstrValid), .Instr(Instr),
    .InstrPC(InstrPC), .InstrPCPlus4(InstrPCPlus4)
`ifdef FETCH_PERF_CNT_EN
    , .PerfFetchCnt(PerfFetchCnt), .PerfStarveCnt(PerfStarveCnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_addr;
  bit          pend;
  int          pend_cnt, lat, rdy_hold;
  logic [31:0] pend_addr, last_pop_pc;
  bit          popped, wrap_seen;
  int          n_fetch, n_starve, first, npops, k;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive memory, sample DUT, update model, advance to posedge+1.
  task automatic step();
    exp_t e;
    bit   acc, pop;
    IMemRValid = pend && (pend_cnt == 0);
    IMemRData  = IMemRValid ? mdata(pend_addr) : 32'h0;
    IMemReady  = (rdy_hold == 0);
    #1;
    acc    = IMemReq && IMemReady;
    pop    = InstrValid && InstrReady;
    popped = pop;
    if (IMemReq) chk("imem_addr", IMemAddr, exp_addr);
    if (acc) chk("one_outstanding", 32'(pend && !IMemRValid), 32'd0);
    if (pop) begin
      if (sb.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("instr", Instr, e.ins);
        chk("instr_pc", InstrPC, e.pc);
        chk("pc_plus4", InstrPCPlus4, e.pc + 32'd4);
      end
      last_pop_pc = InstrPC;
      if (InstrPC == 32'hFFFF_FFFC) wrap_seen = 1'b1;
      n_fetch++;
    end
    if (InstrReady && !InstrValid) n_starve++;
    if (acc) begin
      sb.push_back('{exp_addr, mdata(exp_addr)});
      exp_addr += 32'd4;
    end
    if (RedirectValid) begin
      sb.delete();
      exp_addr = {RedirectPC[31:2], 2'b00};
    end
    if (IMemRValid) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = lat - 1;
      pend_addr = IMemAddr;
    end
    if (rdy_hold > 0) rdy_hold--;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_addr = 32'h0; pend = 1'b0; pend_cnt = 0; pend_addr = '0; lat = 1; rdy_hold = 0;
    n_fetch = 0; n_starve = 0; wrap_seen = 1'b0; last_pop_pc = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", 32'(IMemReq), 32'd0);
    chk("rst_valid", 32'(InstrValid), 32'd0);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_pc", InstrPC, 32'd0);
    chk("rst_pc4", InstrPCPlus4, 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", PerfFetchCnt, 32'd0);
    chk("rst_perf_starve", PerfStarveCnt, 32'd0);
`endif

    // Streaming with zero-wait memory.
    RST_N = 1'b1; InstrReady = 1'b1;
    first = -1; npops = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (popped) begin
        npops++;
        if (first < 0) first = i;
      end
    end
    chk("first_valid_cycle", 32'(first), 32'd2);
    chk("throughput", 32'(npops), 32'd10);

    // Decode stall: queue fills, request goes quiet.
    InstrReady = 1'b0;
    repeat (10) step();
    chk("stall_valid", 32'(InstrValid), 32'd1);
    chk("stall_req", 32'(IMemReq), 32'd0);
    chk("stall_sb_full", 32'(sb.size()), 32'd2);
    InstrReady = 1'b1;
    repeat (6) step();

    // Redirect with a response in flight.
    RedirectValid = 1'b1; RedirectPC = 32'h0000_0103;
    step();
    RedirectValid = 1'b0;
    k = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (popped && k < 0) begin
        k = i;
        chk("redir_first_pc", last_pop_pc, 32'h0000_0100);
      end
    end
    chk("redir_latency", 32'(k), 32'd2);

    // Slow memory: ready low 3 cycles, response latency 4.
    lat = 4; rdy_hold = 3;
    npops = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (popped) npops++;
    end
    chk("slow_pops", 32'(npops > 0), 32'd1);

    // PC wrap at 2^32.
    lat = 1;
    RedirectValid = 1'b1; RedirectPC = 32'hFFFF_FFF8;
    step();
    RedirectValid = 1'b0;
    repeat (10) step();
    chk("wrap_seen", 32'(wrap_seen), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", PerfFetchCnt, 32'(n_fetch));
    chk("perf_starve", PerfStarveCnt, 32'(n_starve));
`endif

    // Mid-stream reset with a full queue.
    InstrReady = 1'b0;
    repeat (5) step();
    chk("pre_rst_valid", 32'(InstrValid), 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(InstrValid), 32'd0);
    chk("async_rst_req", 32'(IMemReq), 32'd0);
    chk("async_rst_pc", InstrPC, 32'd0);
    chk("async_rst_pc4", InstrPCPlus4, 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("async_rst_perf_fetch", PerfFetchCnt, 32'd0);
    chk("async_rst_perf_starve", PerfStarveCnt, 32'd0);
`endif
    sb.delete(); exp_addr = 32'h0; n_fetch = 0; n_starve = 0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1; InstrReady = 1'b1;
    k = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (popped && k < 0) begin
        k = i;
        chk("restart_pc", last_pop_pc, 32'h0);
      end
    end
    chk("restart_latency", 32'(k), 32'd2);
`ifdef FETCH_PERF_CNT_EN
    chk("end_perf_fetch", PerfFetchCnt, 32'(n_fetch));
    chk("end_perf_starve", PerfStarveCnt, 32'(n_starve));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
